// File: rtl/alu_issue_sequencer.sv
// Decodes oper/func into ALU control code and PSR write mask, sequencing multiply over MUL_CYCLES cycles.
// Latency: 1 cycle fire-to-out_valid for single-cycle ops, MUL_CYCLES cycles for MUL/MULI.
// Backpressure: result held stable in HOLD until out_ready; in_ready follows out_ready there for back-to-back issue.
module alu_issue_sequencer #(
    parameter int MUL_CYCLES   = 4,
    parameter int CNT_W        = 3,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] oper,
    input  logic [3:0] func,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] alu_cont,
    output logic [4:0] psr_wr_en,
    output logic       busy,
    output logic       illegal
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       code_q, code_d;
    logic [4:0]       mask_q, mask_d;
    logic             ill_q, ill_d;

    logic       dec_legal;
    logic       dec_mul;
    logic       alu_grp;
    logic [3:0] efunc;
    logic [4:0] dec_code;
    logic [4:0] dec_mask;
    logic       fire;

    // Instruction decode: ALU-group opers (0000 and immediates) share the func table.
    always_comb begin
        dec_legal = 1'b1;
        dec_mul   = 1'b0;
        dec_code  = 5'b00000;
        dec_mask  = 5'b00000;
        alu_grp   = 1'b0;
        efunc     = func;
        case (oper)
            4'h0: begin
                alu_grp = 1'b1;
                efunc   = func;
            end
            4'h4: begin
                case (func)
                    4'h8:    dec_code = 5'b01000;
                    4'hC:    dec_code = 5'b10001;
                    4'hD:    dec_code = 5'b00111;
                    default: dec_legal = 1'b0;
                endcase
            end
            4'h8: begin
                case (func)
                    4'h0, 4'h2: dec_code = 5'b01100;
                    4'h1:       dec_code = 5'b01101;
                    4'h3:       dec_code = 5'b01111;
                    4'h4:       dec_code = 5'b01011;
                    4'h6:       dec_code = 5'b01110;
                    default:    dec_legal = 1'b0;
                endcase
            end
            4'hC:    dec_code = 5'b10000;
            4'hF:    dec_code = 5'b01001;
            default: begin
                alu_grp = 1'b1;
                efunc   = oper;
            end
        endcase
        if (alu_grp) begin
            case (efunc)
                4'h1, 4'hF: begin dec_code = 5'b00011; dec_mask = 5'b00010; end
                4'h2:       begin dec_code = 5'b00100; dec_mask = 5'b00010; end
                4'h3:       begin dec_code = 5'b00101; dec_mask = 5'b00010; end
                4'h4:       begin dec_code = 5'b01010; dec_mask = 5'b00010; end
                4'h5, 4'h6: begin dec_code = 5'b00000; dec_mask = 5'b10111; end
                4'h7:       begin dec_code = 5'b00000; dec_mask = 5'b00000; end
                4'h9, 4'hA: begin dec_code = 5'b00001; dec_mask = 5'b10111; end
                4'hB:       begin dec_code = 5'b00001; dec_mask = 5'b01011; end
                4'hD:       dec_code = 5'b01000;
                4'hE:       begin dec_code = 5'b00010; dec_mul = 1'b1; end
                default:    dec_legal = 1'b0;
            endcase
            // CMPI updates the full arithmetic flag set, unlike register CMP.
            if (oper == 4'hB) begin
                dec_mask = 5'b10111;
            end
        end
        // Illegal encodings degrade to a flagless ADD; only the illegal flag depends on trapping.
        if (!dec_legal) begin
            dec_code = 5'b00000;
            dec_mask = 5'b00000;
            dec_mul  = 1'b0;
        end
    end

    assign in_ready = !reset && !flush &&
                      ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    assign fire     = in_valid && in_ready;

    // Next-state: accept, count down multiply, hold until consumed; flush overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        mask_d  = mask_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready && !fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fire) begin
            code_d = dec_code;
            mask_d = dec_mask;
            ill_d  = !dec_legal && (ILLEGAL_TRAP != 0);
            if (dec_mul && (MUL_CYCLES > 1)) begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
            end else begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        end
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // State and latched decode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= 5'b00000;
            mask_q  <= 5'b00000;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_MUL);
    assign illegal   = out_valid && ill_q;
    assign alu_cont  = busy ? 5'b00010 : (out_valid ? code_q : 5'b00000);
    // PSR is written only on the consuming handshake so stalls never double-write.
    assign psr_wr_en = (out_valid && out_ready) ? mask_q : 5'b00000;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
module tb_alu_issue_sequencer;

    localparam int MULC = 4;

    logic       clk = 1'b0;
    logic       reset, in_valid, flush, out_ready;
    logic [3:0] oper, func;

    logic       in_ready, out_valid, busy, illegal;
    logic [4:0] alu_cont, psr_wr_en;
    logic       in_ready2, out_valid2, busy2, illegal2;
    logic [4:0] alu_cont2, psr_wr_en2;

    int total = 0;
    int bad   = 0;

    // Reference model: an accepted instruction becomes visible after rem cycles.
    bit         m_have = 0;
    int         m_rem  = 0;
    logic [4:0] m_code = 0, m_mask = 0;
    bit         m_ill  = 0;
    bit         e_ovld, e_busy, e_inrdy, e_ill;
    logic [4:0] e_alu, e_psr;

    localparam logic [7:0] ENC [0:31] = '{
        8'h01, 8'h0F, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
        8'h09, 8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h10, 8'h3A, 8'h5C,
        8'hB3, 8'hE0, 8'h48, 8'h4C, 8'h4D, 8'h80, 8'h81, 8'h82,
        8'h83, 8'h84, 8'h86, 8'hC5, 8'hF2, 8'h40, 8'h00, 8'h85};

    always #5 clk = ~clk;

    alu_issue_sequencer #(.MUL_CYCLES(MULC), .CNT_W(3), .ILLEGAL_TRAP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .oper(oper), .func(func), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_cont(alu_cont), .psr_wr_en(psr_wr_en),
        .busy(busy), .illegal(illegal));

    alu_issue_sequencer #(.MUL_CYCLES(MULC), .CNT_W(3), .ILLEGAL_TRAP(0)) dut_nt (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .oper(oper), .func(func), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .alu_cont(alu_cont2), .psr_wr_en(psr_wr_en2),
        .busy(busy2), .illegal(illegal2));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Decode rules: returns legality, multiply flag, control code and flag mask.
    function automatic void ref_decode(input logic [3:0] op, input logic [3:0] fn,
                                       output bit legal, output bit mul,
                                       output logic [4:0] code, output logic [4:0] mask);
        logic [3:0] f;
        legal = 1; mul = 0; code = 0; mask = 0;
        if (op == 4'h4) begin
            if (fn == 4'h8) code = 5'b01000;
            else if (fn == 4'hC) code = 5'b10001;
            else if (fn == 4'hD) code = 5'b00111;
            else legal = 0;
        end else if (op == 4'h8) begin
            if (fn == 4'h0 || fn == 4'h2) code = 5'b01100;
            else if (fn == 4'h1) code = 5'b01101;
            else if (fn == 4'h3) code = 5'b01111;
            else if (fn == 4'h4) code = 5'b01011;
            else if (fn == 4'h6) code = 5'b01110;
            else legal = 0;
        end else if (op == 4'hC) begin
            code = 5'b10000;
        end else if (op == 4'hF) begin
            code = 5'b01001;
        end else begin
            f = (op == 4'h0) ? fn : op;
            if (f == 4'h1 || f == 4'hF) begin code = 5'b00011; mask = 5'b00010; end
            else if (f == 4'h2) begin code = 5'b00100; mask = 5'b00010; end
            else if (f == 4'h3) begin code = 5'b00101; mask = 5'b00010; end
            else if (f == 4'h4) begin code = 5'b01010; mask = 5'b00010; end
            else if (f == 4'h5 || f == 4'h6) begin code = 5'b00000; mask = 5'b10111; end
            else if (f == 4'h7) begin code = 5'b00000; mask = 5'b00000; end
            else if (f == 4'h9 || f == 4'hA) begin code = 5'b00001; mask = 5'b10111; end
            else if (f == 4'hB) begin code = 5'b00001; mask = (op == 4'hB) ? 5'b10111 : 5'b01011; end
            else if (f == 4'hD) code = 5'b01000;
            else if (f == 4'hE) begin code = 5'b00010; mul = 1; end
            else legal = 0;
        end
        if (!legal) begin code = 0; mask = 0; end
    endfunction

    // Apply inputs at the falling edge and compare both DUTs with the model.
    task automatic drive_chk(input bit rst, input bit iv, input logic [3:0] op,
                             input logic [3:0] fn, input bit fl, input bit ordy);
        reset = rst; in_valid = iv; oper = op; func = fn; flush = fl; out_ready = ordy;
        #1;
        e_ovld  = m_have && (m_rem == 0);
        e_busy  = m_have && (m_rem > 0);
        e_alu   = e_busy ? 5'b00010 : (e_ovld ? m_code : 5'b00000);
        e_inrdy = !rst && !fl && (!m_have || (e_ovld && ordy));
        e_psr   = (e_ovld && ordy) ? m_mask : 5'b00000;
        e_ill   = e_ovld && m_ill;
        chk("out_valid", {7'b0, out_valid}, {7'b0, e_ovld});
        chk("busy",      {7'b0, busy},      {7'b0, e_busy});
        chk("in_ready",  {7'b0, in_ready},  {7'b0, e_inrdy});
        chk("alu_cont",  {3'b0, alu_cont},  {3'b0, e_alu});
        chk("psr_wr_en", {3'b0, psr_wr_en}, {3'b0, e_psr});
        chk("illegal",   {7'b0, illegal},   {7'b0, e_ill});
        chk("nt_out_valid", {7'b0, out_valid2}, {7'b0, e_ovld});
        chk("nt_alu_cont",  {3'b0, alu_cont2},  {3'b0, e_alu});
        chk("nt_psr_wr_en", {3'b0, psr_wr_en2}, {3'b0, e_psr});
        chk("nt_illegal",   {7'b0, illegal2},   8'h00);
    endtask

    // Advance the model across the rising edge, then return to the falling edge.
    task automatic advance();
        bit legal, mul;
        logic [4:0] c, m;
        if (reset || flush) begin
            m_have = 0;
        end else begin
            if (e_busy) m_rem--;
            if (e_ovld && out_ready) m_have = 0;
            if (in_valid && e_inrdy) begin
                ref_decode(oper, func, legal, mul, c, m);
                m_have = 1;
                m_rem  = mul ? MULC - 1 : 0;
                m_code = c;
                m_mask = m;
                m_ill  = !legal;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1; in_valid = 0; oper = 0; func = 0; flush = 0; out_ready = 0;
        @(negedge clk);
        drive_chk(1, 0, 0, 0, 0, 1); advance();

        // ADD, one-cycle latency, flags CLFZN mask on handshake.
        drive_chk(0, 1, 4'h0, 4'h5, 0, 1); advance();
        drive_chk(0, 0, 0, 0, 0, 1);
        chk("add_vld", {7'b0, out_valid}, 8'h01);
        chk("add_psr", {3'b0, psr_wr_en}, 8'h17);
        advance();
        drive_chk(0, 0, 0, 0, 0, 1);
        chk("add_gone", {7'b0, out_valid}, 8'h00);
        advance();

        // MUL: three busy cycles, valid on the fourth.
        drive_chk(0, 1, 4'hE, 4'h0, 0, 1); advance();
        for (int i = 0; i < 3; i++) begin
            drive_chk(0, 0, 0, 0, 0, 1);
            chk("mul_busy", {7'b0, busy}, 8'h01);
            advance();
        end
        drive_chk(0, 0, 0, 0, 0, 1);
        chk("mul_vld", {7'b0, out_valid}, 8'h01);
        advance();

        // CMP stalled three cycles, then consumed once.
        drive_chk(0, 1, 4'h0, 4'hB, 0, 0); advance();
        for (int i = 0; i < 3; i++) begin
            drive_chk(0, 0, 0, 0, 0, 0);
            chk("cmp_stall_psr", {3'b0, psr_wr_en}, 8'h00);
            advance();
        end
        drive_chk(0, 0, 0, 0, 0, 1);
        chk("cmp_psr", {3'b0, psr_wr_en}, 8'h0B);
        advance();
        drive_chk(0, 0, 0, 0, 0, 1); advance();

        // Back-to-back AND then shift-right immediate.
        drive_chk(0, 1, 4'h0, 4'h1, 0, 1); advance();
        drive_chk(0, 1, 4'h8, 4'h1, 0, 1);
        chk("b2b_and", {3'b0, alu_cont}, 8'h03);
        advance();
        drive_chk(0, 0, 0, 0, 0, 1);
        chk("b2b_lsh", {3'b0, alu_cont}, 8'h0D);
        advance();

        // Illegal encoding, trapping and non-trapping instances.
        drive_chk(0, 1, 4'h4, 4'h0, 0, 1); advance();
        drive_chk(0, 0, 0, 0, 0, 1);
        chk("ill_flag", {7'b0, illegal}, 8'h01);
        advance();

        // Flush, then reset, during multiply count 2.
        for (int k = 0; k < 2; k++) begin
            drive_chk(0, 1, 4'hE, 4'h0, 0, 1); advance();
            drive_chk(0, 0, 0, 0, 0, 1); advance();
            drive_chk(k == 1, 1, 4'h0, 4'h5, k == 0, 1); advance();
            for (int i = 0; i < 5; i++) begin
                drive_chk(0, 0, 0, 0, 0, 1);
                chk("abort_novld", {7'b0, out_valid}, 8'h00);
                advance();
            end
        end

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [7:0] enc;
            enc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ENC[$urandom_range(0, 31)];
            drive_chk($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, enc[7:4], enc[3:0],
                      $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
